// File: rtl/sysbus_ctl_if.sv
// Bundle of request, grant, response and status lines between the bus-cycle
// controller and its environment (state-control unit plus system-bus arbiter).
interface sysbus_ctl_if;
    logic zgi;
    logic zw;
    logic ok;
    logic en;
    logic pe;
    logic zg;
    logic zwzg;
    logic oken;
    logic alarm;
    logic perr;

    modport master (
        input  zgi, zw, ok, en, pe,
        output zg, zwzg, oken, alarm, perr
    );

    modport slave (
        output zgi, zw, ok, en, pe,
        input  zg, zwzg, oken, alarm, perr
    );
endinterface

// File: rtl/sysbus_ctl.sv
// System-bus cycle controller: requests the bus, drives a granted cycle,
// waits for OK/EN/PE and raises alarm if no response arrives within TIMEOUT.
//
// state | meaning
// IDLE  | no bus activity, waiting for zgi
// REQ   | zg raised, waiting for synchronized grant
// XFER  | bus drivers enabled, timeout counter running
// RESP  | response seen, waiting for all response lines to drop
// REL   | bus released, waiting for zgi to drop
// ALRM  | no response in time, alarm held until zgi drops
module sysbus_ctl #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic          __clk,
    input  logic          clo_n,
    sysbus_ctl_if.master  bus
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_XFER = 3'd2;
    localparam logic [2:0] S_RESP = 3'd3;
    localparam logic [2:0] S_REL  = 3'd4;
    localparam logic [2:0] S_ALRM = 3'd5;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    logic [2:0] state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] sync1_q, sync1_d;
    logic [3:0] sync2_q, sync2_d;
    logic       arm_q, arm_d;
    logic       resp_first_q, resp_first_d;
    logic       zg_q, zg_d;
    logic       zwzg_q, zwzg_d;
    logic       oken_q, oken_d;
    logic       alarm_q, alarm_d;
    logic       perr_q, perr_d;

    logic zw_s, ok_s, en_s, pe_s, any_resp;

    assign zw_s     = sync2_q[3];
    assign ok_s     = sync2_q[2];
    assign en_s     = sync2_q[1];
    assign pe_s     = sync2_q[0];
    assign any_resp = ok_s | en_s | pe_s;

    always_comb begin
        sync1_d      = {bus.zw, bus.ok, bus.en, bus.pe};
        sync2_d      = sync1_q;
        // arm_q keeps a request from being taken on the first edge after reset release
        arm_d        = 1'b1;
        state_d      = state_q;
        cnt_d        = cnt_q;
        perr_d       = perr_q;
        resp_first_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.zgi && arm_q) begin
                    state_d = S_REQ;
                    perr_d  = 1'b0;
                end
            end
            S_REQ: begin
                if (zw_s) begin
                    state_d = S_XFER;
                    cnt_d   = 8'd0;
                end else if (!bus.zgi) begin
                    state_d = S_IDLE;
                end
            end
            S_XFER: begin
                cnt_d = cnt_q + 8'd1;
                // a response in the timeout cycle still wins over the alarm
                if (any_resp) begin
                    state_d      = S_RESP;
                    resp_first_d = ok_s | en_s;
                    if (pe_s) perr_d = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_ALRM;
                end
            end
            S_RESP: begin
                if (!any_resp) state_d = S_REL;
            end
            S_REL, S_ALRM: begin
                if (!bus.zgi) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        zg_d    = (state_q == S_REQ) || (state_q == S_XFER) || (state_q == S_RESP);
        zwzg_d  = (state_q == S_XFER);
        alarm_d = (state_q == S_ALRM);
        oken_d  = resp_first_q;
    end

    always_ff @(posedge __clk or negedge clo_n) begin
        if (!clo_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= 8'd0;
            sync1_q      <= 4'd0;
            sync2_q      <= 4'd0;
            arm_q        <= 1'b0;
            resp_first_q <= 1'b0;
            zg_q         <= 1'b0;
            zwzg_q       <= 1'b0;
            oken_q       <= 1'b0;
            alarm_q      <= 1'b0;
            perr_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            arm_q        <= arm_d;
            resp_first_q <= resp_first_d;
            zg_q         <= zg_d;
            zwzg_q       <= zwzg_d;
            oken_q       <= oken_d;
            alarm_q      <= alarm_d;
            perr_q       <= perr_d;
        end
    end

    assign bus.zg    = zg_q;
    assign bus.zwzg  = zwzg_q;
    assign bus.oken  = oken_q;
    assign bus.alarm = alarm_q;
    assign bus.perr  = perr_q;

endmodule

// File: tb/tb_sysbus_ctl.sv
// Bench for sysbus_ctl: expected output waveforms are derived from the event
// times of each stimulus scenario (request, grant, response, release).
module tb_sysbus_ctl;

    logic clk;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   scen    = 0;
    int   cyc     = 0;
    bit   perr_cur [2];

    sysbus_ctl_if if64 ();
    sysbus_ctl_if if4 ();

    sysbus_ctl #(.TIMEOUT(64)) dut64 (.__clk(clk), .clo_n(rst_n), .bus(if64));
    sysbus_ctl #(.TIMEOUT(4))  dut4  (.__clk(clk), .clo_n(rst_n), .bus(if4));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic drive(input bit sel, input logic zgi, input logic zw,
                         input logic ok, input logic en, input logic pe);
        if (sel) begin
            if4.zgi = zgi; if4.zw = zw; if4.ok = ok; if4.en = en; if4.pe = pe;
        end else begin
            if64.zgi = zgi; if64.zw = zw; if64.ok = ok; if64.en = en; if64.pe = pe;
        end
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s scen=%0d cyc=%0d observed=%b expected=%b", tag, scen, cyc, obs, exp);
        end
    endtask

    task automatic check_outs(input bit sel, input logic ezg, input logic ezwzg,
                              input logic eoken, input logic ealarm, input logic eperr);
        chk(sel ? "zg4"    : "zg64",    sel ? if4.zg    : if64.zg,    ezg);
        chk(sel ? "zwzg4"  : "zwzg64",  sel ? if4.zwzg  : if64.zwzg,  ezwzg);
        chk(sel ? "oken4"  : "oken64",  sel ? if4.oken  : if64.oken,  eoken);
        chk(sel ? "alarm4" : "alarm64", sel ? if4.alarm : if64.alarm, ealarm);
        chk(sel ? "perr4"  : "perr64",  sel ? if4.perr  : if64.perr,  eperr);
    endtask

    // kind: 0 ok, 1 en, 2 pe, 3 ok+pe, 4 no response.
    // Inputs applied after edge i are first seen at edge i+1; the DUT's
    // synchronizers add two edges and the output register one more.
    task automatic run_xfer(input bit sel, input int kind, input int a, input int rd,
                            input int hold, input int extra, input int zwdrop);
        int T, X, r, C, A, d, g, dr, L, zwoff;
        bit wins, okev, pev, hasresp;
        logic ezg, ezwzg, eoken, ealarm, eperr, rv;
        T       = sel ? 4 : 64;
        X       = a + 3;
        r       = X + rd;
        hasresp = (kind != 4);
        okev    = (kind == 0) || (kind == 1) || (kind == 3);
        pev     = (kind == 2) || (kind == 3);
        wins    = hasresp && (r + 3 <= X + T);
        C = 0; A = 0; d = 0;
        if (wins) begin
            C  = r + 3;
            d  = C + hold;
            g  = d + extra;
            dr = d;
            L  = g + 6;
        end else begin
            A  = X + T;
            g  = A + 1 + extra;
            dr = (r + 1 > g) ? r + 1 : g;
            L  = ((dr > g) ? dr : g) + 6;
        end
        zwoff = a + 4 + zwdrop;
        scen++;
        for (int i = 0; i <= L; i++) begin
            @(posedge clk); #1;
            rv = hasresp && (i >= r) && (i < dr);
            drive(sel, i < g, (i >= a) && (i < zwoff),
                  rv && (kind == 0 || kind == 3), rv && (kind == 1), rv && pev);
            @(negedge clk);
            cyc = i;
            if (wins) begin
                ezg    = (i >= 2) && (i <= d + 3);
                ezwzg  = (i >= X + 1) && (i <= C);
                eoken  = okev && (i == C + 1);
                ealarm = 1'b0;
                eperr  = (i == 0) ? perr_cur[sel] : (pev && i >= C);
            end else begin
                ezg    = (i >= 2) && (i <= A);
                ezwzg  = (i >= X + 1) && (i <= A);
                eoken  = 1'b0;
                ealarm = (i >= A + 1) && (i <= g + 1);
                eperr  = (i == 0) ? perr_cur[sel] : 1'b0;
            end
            check_outs(sel, ezg, ezwzg, eoken, ealarm, eperr);
        end
        perr_cur[sel] = wins && pev;
    endtask

    task automatic run_abort(input bit sel, input int k);
        scen++;
        for (int i = 0; i <= k + 5; i++) begin
            @(posedge clk); #1;
            drive(sel, i < k, 1'b0, 1'b0, 1'b0, 1'b0);
            @(negedge clk);
            cyc = i;
            check_outs(sel, (i >= 2) && (i <= k + 1), 1'b0, 1'b0, 1'b0,
                       (i == 0) ? perr_cur[sel] : 1'b0);
        end
        perr_cur[sel] = 1'b0;
    endtask

    task automatic run_reset();
        scen++;
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("zwzg_before_reset", if64.zwzg, 1'b1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check_outs(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        rst_n = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int j = 0; j <= 4; j++) begin
            @(negedge clk);
            cyc = j;
            check_outs(1'b0, j >= 3, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        perr_cur[0] = 1'b0;
        perr_cur[1] = 1'b0;
    endtask

    initial begin
        bit sel;
        int kind, rd;
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        perr_cur[0] = 1'b0;
        perr_cur[1] = 1'b0;
        #2;
        check_outs(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_outs(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #20;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);

        run_xfer(1'b0, 0, 3, 10, 2, 0, 1);   // plain OK cycle
        run_xfer(1'b0, 4, 2, 0, 0, 2, 0);    // no response: 64-cycle timeout
        run_xfer(1'b0, 3, 1, 5, 1, 0, 2);    // OK+PE: oken and sticky perr
        run_abort(1'b0, 2);                  // next request clears perr, abort before grant
        run_xfer(1'b1, 0, 2, 1, 0, 0, 0);    // TIMEOUT=4, OK on the timeout cycle
        run_xfer(1'b1, 0, 2, 2, 0, 1, 0);    // TIMEOUT=4, OK one cycle late
        run_xfer(1'b0, 1, 4, 61, 0, 0, 3);   // EN on the last cycle before timeout
        run_xfer(1'b0, 2, 4, 62, 0, 0, 3);   // PE one cycle too late
        run_reset();
        run_xfer(1'b0, 0, 1, 3, 0, 8, 0);    // zgi held in REL: no re-request

        for (int n = 0; n < 40; n++) begin
            sel = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 5) == 0) begin
                run_abort(sel, int'($urandom_range(1, 4)));
            end else begin
                kind = int'($urandom_range(0, 4));
                if (sel)
                    rd = int'($urandom_range(1, 6));
                else if ($urandom_range(0, 1) == 1)
                    rd = int'($urandom_range(1, 20));
                else
                    rd = int'($urandom_range(58, 66));
                run_xfer(sel, kind, int'($urandom_range(1, 6)), rd,
                         int'($urandom_range(0, 3)), int'($urandom_range(0, 5)),
                         int'($urandom_range(0, 3)));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
